// File: rtl/uart_rx_deser_pkg.sv
// Shared UART receive definitions: FSM states, oversampling constants and the
// majority-vote helper used at the middle of each bit.
package uart_rx_deser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int OS_W       = $clog2(OVERSAMPLE);

    // Oversample ticks that carry the three votes, and the last tick of a bit
    localparam logic [OS_W-1:0] VOTE_LO  = OS_W'(7);
    localparam logic [OS_W-1:0] VOTE_MID = OS_W'(8);
    localparam logic [OS_W-1:0] VOTE_HI  = OS_W'(9);
    localparam logic [OS_W-1:0] BIT_END  = OS_W'(15);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every div_i+1 clocks. A clear
// restarts the count so ticks can be phase-aligned to a line edge.
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clear_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] div_cnt_q;
    logic [DIV_WIDTH-1:0] div_cnt_d;

    assign tick_o = (div_cnt_q == div_i);

    always_comb begin
        if (clear_i || tick_o) div_cnt_d = '0;
        else                   div_cnt_d = div_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) div_cnt_q <= '0;
        else       div_cnt_q <= div_cnt_d;
    end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: synchronizes and 16x-oversamples rx_in, checks
// start/parity/stop and emits a single push strobe or error pulse per frame.
module uart_rx_deser
    import uart_rx_deser_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rx_in,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 fifo_full,
    output logic                 fifo_wr_en,
    output logic [DATA_BITS-1:0] fifo_wr_data,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 rx_busy
);

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic                 rx_meta_q, rx_s_q;
    rx_state_e            state_q, state_d;
    logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 v_lo_q, v_lo_d, v_mid_q, v_mid_d;
    logic                 par_bit_q, par_bit_d;
    logic                 armed_q, armed_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 par_en_q, par_en_d, par_odd_q, par_odd_d;
    logic                 wr_en_q, wr_en_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_err_q, overrun_err_d;
    logic                 busy_q;
    logic                 tick, tick_clr, vote, parity_ok;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud_tick (
        .clk     (clk),
        .rstn    (rstn),
        .clear_i (tick_clr),
        .div_i   (div_q),
        .tick_o  (tick)
    );

    assign vote      = maj3(v_lo_q, v_mid_q, rx_s_q);
    assign parity_ok = (((^shreg_q) ^ par_odd_q) == par_bit_q);

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_d       = state_q;
        os_cnt_d      = os_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        v_lo_d        = v_lo_q;
        v_mid_d       = v_mid_q;
        par_bit_d     = par_bit_q;
        armed_d       = armed_q;
        div_d         = div_q;
        par_en_d      = par_en_q;
        par_odd_d     = par_odd_q;
        tick_clr      = 1'b0;
        wr_en_d       = 1'b0;
        wr_data_d     = wr_data_q;
        frame_err_d   = 1'b0;
        parity_err_d  = 1'b0;
        overrun_err_d = 1'b0;

        if (state_q != ST_IDLE && tick) begin
            os_cnt_d = os_cnt_q + 1'b1;
            if (os_cnt_q == VOTE_LO)  v_lo_d  = rx_s_q;
            if (os_cnt_q == VOTE_MID) v_mid_d = rx_s_q;
        end

        case (state_q)
            ST_IDLE: begin
                // A line that has stayed low since the last frame must go high before re-arming
                if (!armed_q) begin
                    armed_d = rx_s_q;
                end else if (!rx_s_q) begin
                    state_d   = ST_START;
                    armed_d   = 1'b0;
                    tick_clr  = 1'b1;
                    os_cnt_d  = '0;
                    bit_cnt_d = '0;
                    div_d     = baud_div;
                    par_en_d  = parity_en;
                    par_odd_d = parity_odd;
                end
            end
            ST_START: if (tick) begin
                if (os_cnt_q == VOTE_HI && vote) state_d = ST_IDLE;
                else if (os_cnt_q == BIT_END)    state_d = ST_DATA;
            end
            ST_DATA: if (tick) begin
                if (os_cnt_q == VOTE_HI) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                if (os_cnt_q == BIT_END) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: if (tick) begin
                if (os_cnt_q == VOTE_HI) par_bit_d = vote;
                if (os_cnt_q == BIT_END) state_d   = ST_STOP;
            end
            ST_STOP: if (tick && os_cnt_q == VOTE_HI) begin
                // Leave mid stop bit so the next start edge is caught with half a bit of margin
                state_d = ST_IDLE;
                if (!vote)                         frame_err_d   = 1'b1;
                else if (par_en_q && !parity_ok)   parity_err_d  = 1'b1;
                else if (fifo_full)                overrun_err_d = 1'b1;
                else begin
                    wr_en_d   = 1'b1;
                    wr_data_d = shreg_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            os_cnt_q      <= '0;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            v_lo_q        <= 1'b1;
            v_mid_q       <= 1'b1;
            par_bit_q     <= 1'b0;
            armed_q       <= 1'b0;
            div_q         <= '0;
            par_en_q      <= 1'b0;
            par_odd_q     <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_data_q     <= '0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            os_cnt_q      <= os_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            v_lo_q        <= v_lo_d;
            v_mid_q       <= v_mid_d;
            par_bit_q     <= par_bit_d;
            armed_q       <= armed_d;
            div_q         <= div_d;
            par_en_q      <= par_en_d;
            par_odd_q     <= par_odd_d;
            wr_en_q       <= wr_en_d;
            wr_data_q     <= wr_data_d;
            frame_err_q   <= frame_err_d;
            parity_err_q  <= parity_err_d;
            overrun_err_q <= overrun_err_d;
            busy_q        <= (state_d != ST_IDLE);
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign frame_err    = frame_err_q;
    assign parity_err   = parity_err_q;
    assign overrun_err  = overrun_err_q;
    assign rx_busy      = busy_q;

endmodule
